// File: rtl/spart_driver_if.sv
// Control half of the SPART processor bus: chip select, direction, register address.
// The shared data lines remain a plain inout port on spart_driver.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  modport master (output iocs, iorw, ioaddr);
  modport slave  (input  iocs, iorw, ioaddr);
endinterface

// File: rtl/spart_driver.sv
// SPART echo driver: programs the baud divisor, then polls status and echoes
// every received byte back to the transmitter, reprogramming when br_cfg changes.
module spart_driver #(
  parameter int CLK_HZ = 100000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]    databus,
  output logic [7:0]    echo_cnt,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG_LO   = 3'd1,
    CFG_HI   = 3'd2,
    POLL     = 3'd3,
    READ_RX  = 3'd4,
    WAIT_TBR = 3'd5,
    WRITE_TX = 3'd6
  } state_t;

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800)  - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600)  - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

  state_t      r_state;
  logic [1:0]  r_br_q;
  logic        r_reconfig_pending;
  logic [7:0]  r_rx_byte;
  logic [7:0]  r_echo_cnt;

  logic [15:0] w_divisor;
  logic        w_drive;
  logic [7:0]  w_wdata;
  logic        w_in_cfg;

  always_comb begin
    w_divisor = DIV_4800;
    case (r_br_q)
      2'b00:   w_divisor = DIV_4800;
      2'b01:   w_divisor = DIV_9600;
      2'b10:   w_divisor = DIV_19200;
      default: w_divisor = DIV_38400;
    endcase
  end

  // Bus controls are a pure decode of the state register, so reset clears them at once.
  always_comb begin
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    w_drive    = 1'b0;
    w_wdata    = 8'h00;
    case (r_state)
      IDLE:     bus.iocs = 1'b0;
      CFG_LO:   begin bus.iorw = 1'b0; bus.ioaddr = 2'b10; w_drive = 1'b1; w_wdata = w_divisor[7:0];  end
      CFG_HI:   begin bus.iorw = 1'b0; bus.ioaddr = 2'b11; w_drive = 1'b1; w_wdata = w_divisor[15:8]; end
      POLL:     bus.ioaddr = 2'b01;
      READ_RX:  bus.ioaddr = 2'b00;
      WAIT_TBR: bus.ioaddr = 2'b01;
      WRITE_TX: begin bus.iorw = 1'b0; bus.ioaddr = 2'b00; w_drive = 1'b1; w_wdata = r_rx_byte; end
      default:  bus.iocs = 1'b0;
    endcase
  end

  assign databus  = w_drive ? w_wdata : 8'bz;
  assign w_in_cfg = (r_state == CFG_LO) || (r_state == CFG_HI);
  assign echo_cnt = r_echo_cnt;
  assign busy     = (r_state != POLL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_br_q             <= 2'b00;
      r_reconfig_pending <= 1'b0;
      r_rx_byte          <= 8'h00;
      r_echo_cnt         <= 8'h00;
    end else begin
      if (!w_in_cfg && (br_cfg != r_br_q))
        r_reconfig_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          r_state            <= CFG_LO;
          r_br_q             <= br_cfg;
          r_reconfig_pending <= 1'b0;
        end
        CFG_LO: r_state <= CFG_HI;
        CFG_HI: r_state <= POLL;
        POLL: begin
          // A pending reconfiguration is only taken here, so an echo in flight always finishes.
          if (r_reconfig_pending) begin
            r_state            <= CFG_LO;
            r_br_q             <= br_cfg;
            r_reconfig_pending <= 1'b0;
          end else if (databus[0]) begin
            r_state <= READ_RX;
          end
        end
        READ_RX: begin
          r_rx_byte <= databus;
          r_state   <= WAIT_TBR;
        end
        WAIT_TBR: if (databus[1]) r_state <= WRITE_TX;
        WRITE_TX: begin
          r_echo_cnt <= r_echo_cnt + 8'd1;
          r_state    <= POLL;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
